// File: rtl/spi_slave_regs_if.sv
// SPI pin and register-port bundle for spi_slave_regs.
// slave modport is the endpoint; master modport is the SPI master / register-file side.
interface spi_slave_regs_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              i_sclk;
  logic              i_cs_n;
  logic              i_mosi;
  logic              o_miso;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic              o_busy;
  logic              o_frame_err;
  logic              o_irq;
  logic              i_irq_clr;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_rd_data, i_irq_clr,
    output o_miso, o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr,
           o_busy, o_frame_err, o_irq
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_rd_data, i_irq_clr,
    input  o_miso, o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr,
           o_busy, o_frame_err, o_irq
  );
endinterface

// File: rtl/spi_slave_regs.sv
// Oversampling SPI mode-0 slave turning header+data frames into register writes/reads.
// Optional feature macro: SPI_SLAVE_IRQ_EN (sticky write-complete interrupt on o_irq).
module spi_slave_regs #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic             FCLK_CLK0,
  input  logic             RST_N,
  spi_slave_regs_if.slave  bus
);
  localparam int unsigned HDR_W = 8;
  localparam int unsigned CNT_W = $clog2(((DATA_W > HDR_W) ? DATA_W : HDR_W) + 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_t;

  state_t            state;
  logic [2:0]        sclk_sync;
  logic [2:0]        cs_sync;
  logic [1:0]        mosi_sync;
  logic [CNT_W-1:0]  bit_cnt;
  logic [HDR_W-1:0]  hdr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic              rd_load;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic              last_hdr, last_data;
  logic [HDR_W-1:0]  hdr_nxt;
  logic [DATA_W-1:0] rx_nxt;

  // CS_N sync resets to "selected" so a frame in flight at reset release is never picked up mid-way
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], bus.i_sclk};
      cs_sync   <= {cs_sync[1:0], bus.i_cs_n};
      mosi_sync <= {mosi_sync[0], bus.i_mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign mosi_s    = mosi_sync[1];
  assign last_hdr  = (bit_cnt == CNT_W'(HDR_W - 1));
  assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));
  assign hdr_nxt   = {hdr[HDR_W-2:0], mosi_s};
  assign rx_nxt    = {rx_sr[DATA_W-2:0], mosi_s};

  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      hdr             <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      rd_load         <= 1'b0;
      bus.o_miso      <= 1'b0;
      bus.o_wr_en     <= 1'b0;
      bus.o_wr_addr   <= '0;
      bus.o_wr_data   <= '0;
      bus.o_rd_en     <= 1'b0;
      bus.o_rd_addr   <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_wr_en     <= 1'b0;
      bus.o_rd_en     <= 1'b0;
      bus.o_frame_err <= 1'b0;
      rd_load         <= bus.o_rd_en;
      // read data is sampled the cycle after the request
      if (rd_load) tx_sr <= bus.i_rd_data;

      case (state)
        IDLE: begin
          bus.o_miso <= 1'b0;
          if (cs_fall) begin
            state      <= HEADER;
            bit_cnt    <= '0;
            bus.o_busy <= 1'b1;
          end
        end
        HEADER: begin
          if (cs_rise) begin
            state           <= IDLE;
            bus.o_busy      <= 1'b0;
            bus.o_frame_err <= 1'b1;
          end else if (sclk_rise) begin
            hdr <= hdr_nxt;
            if (last_hdr) begin
              state   <= DATA;
              bit_cnt <= '0;
              if (!hdr_nxt[HDR_W-1]) begin
                bus.o_rd_en   <= 1'b1;
                bus.o_rd_addr <= ADDR_W'(hdr_nxt);
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          // a final rise landing with CS_N release still completes the frame
          if (sclk_rise && last_data) begin
            rx_sr      <= rx_nxt;
            state      <= DRAIN;
            bus.o_miso <= 1'b0;
            if (hdr[HDR_W-1]) begin
              bus.o_wr_en   <= 1'b1;
              bus.o_wr_addr <= ADDR_W'(hdr);
              bus.o_wr_data <= rx_nxt;
            end
          end else if (cs_rise) begin
            state           <= IDLE;
            bus.o_busy      <= 1'b0;
            bus.o_frame_err <= 1'b1;
            bus.o_miso      <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr   <= rx_nxt;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else if (sclk_fall && !hdr[HDR_W-1]) begin
            bus.o_miso <= tx_sr[DATA_W-1];
            tx_sr      <= {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
        DRAIN: begin
          bus.o_miso <= 1'b0;
          if (cs_rise) begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  // sticky interrupt; a write in the clearing cycle keeps it set
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      bus.o_irq <= 1'b0;
    end else begin
      bus.o_irq <= bus.o_wr_en | (bus.o_irq & ~bus.i_irq_clr);
    end
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = bus.i_irq_clr;
  assign bus.o_irq      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: drives SPI frames, scoreboards register writes/reads.
module tb_spi_slave_regs;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  spi_slave_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .FCLK_CLK0 (clk),
    .RST_N     (rst_n),
    .bus       (bus.slave)
  );

  txn_t wr_q[$];
  txn_t rd_q[$];
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   err_cnt = 0;
  int   clr_req = 0;
  int   clr_done = 0;
  bit   clr_on_wr = 1'b0;
  int   rd_stage = 0;
  logic [DATA_W-1:0] rd_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard pop, frame-error pulse counter
  always @(negedge clk) begin
    if (bus.o_frame_err === 1'b1) err_cnt++;
    if (bus.o_wr_en === 1'b1) begin
      wr_cnt++;
      check("wr_expected", 64'(wr_q.size() != 0), 64'(1));
      if (wr_q.size() != 0) begin
        txn_t t;
        t = wr_q.pop_front();
        check("wr_addr", 64'(bus.o_wr_addr), 64'(t.addr));
        check("wr_data", 64'(bus.o_wr_data), 64'(t.data));
      end
    end
  end

  // Read responder: data valid only in the cycle after o_rd_en
  always @(negedge clk) begin
    if (rd_stage == 1) begin
      bus.i_rd_data = rd_val;
      rd_stage = 0;
    end else begin
      bus.i_rd_data = '0;
    end
    if (bus.o_rd_en === 1'b1) begin
      rd_cnt++;
      check("rd_expected", 64'(rd_q.size() != 0), 64'(1));
      if (rd_q.size() != 0) begin
        txn_t t;
        t = rd_q.pop_front();
        check("rd_addr", 64'(bus.o_rd_addr), 64'(t.addr));
        rd_val   = t.data;
        rd_stage = 1;
      end
    end
  end

  // Interrupt clear driver: one-cycle pulses on request or coincident with o_wr_en
  always @(negedge clk) begin
    if ((clr_req != clr_done) || (clr_on_wr && bus.o_wr_en === 1'b1)) begin
      clr_done = clr_req;
      bus.i_irq_clr = 1'b1;
    end else begin
      bus.i_irq_clr = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_miso"},   64'(bus.o_miso),      64'(0));
    check({pfx, "_wr_en"},  64'(bus.o_wr_en),     64'(0));
    check({pfx, "_wr_addr"},64'(bus.o_wr_addr),   64'(0));
    check({pfx, "_wr_data"},64'(bus.o_wr_data),   64'(0));
    check({pfx, "_rd_en"},  64'(bus.o_rd_en),     64'(0));
    check({pfx, "_rd_addr"},64'(bus.o_rd_addr),   64'(0));
    check({pfx, "_busy"},   64'(bus.o_busy),      64'(0));
    check({pfx, "_ferr"},   64'(bus.o_frame_err), 64'(0));
    check({pfx, "_irq"},    64'(bus.o_irq),       64'(0));
  endtask

  // One SPI frame: nbits SCLK cycles, MISO captured at each rise; optional reset pulse at bit rst_at
  task automatic frame(input logic [7:0] hdr, input logic [31:0] data, input int nbits,
                       input int rst_at, input bit chk_drain, output logic [31:0] miso_word);
    logic [39:0] sr;
    sr = {hdr, data};
    miso_word = '0;
    @(negedge clk);
    bus.i_cs_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      bus.i_mosi = (i < 40) ? sr[6'(39 - i)] : 1'b0;
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b1;
      if (i >= 8 && i < 40) miso_word[5'(39 - i)] = bus.o_miso;
      if (chk_drain && i >= 40) check("drain_miso", 64'(bus.o_miso), 64'(0));
      if (i == 4 && rst_at < 0) check("busy_in_frame", 64'(bus.o_busy), 64'(1));
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.i_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_after_frame", 64'(bus.o_busy), 64'(0));
  endtask

  initial begin
    logic [31:0] w;
    bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_mosi = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("post_rst");

    // Write 0x85 / 0xDEADBEEF
    wr_q.push_back('{7'h05, 32'hDEADBEEF});
    frame(8'h85, 32'hDEADBEEF, 40, -1, 1'b0, w);
    check("wr1_count", 64'(wr_cnt), 64'(1));
    check("wr1_ferr", 64'(err_cnt), 64'(0));
    check("wr1_rdcnt", 64'(rd_cnt), 64'(0));

    // Read 0x02, register returns 0xA5A50F0F
    rd_q.push_back('{7'h02, 32'hA5A50F0F});
    frame(8'h02, 32'h0, 40, -1, 1'b0, w);
    check("rd1_miso_word", 64'(w), 64'(32'hA5A50F0F));
    check("rd1_count", 64'(rd_cnt), 64'(1));
    check("rd1_wrcnt", 64'(wr_cnt), 64'(1));

    // Short frame: CS_N released after 20 of 40 bits
    frame(8'h81, 32'hFFFF0000, 20, -1, 1'b0, w);
    check("abort_ferr", 64'(err_cnt), 64'(1));
    check("abort_wrcnt", 64'(wr_cnt), 64'(1));
    wr_q.push_back('{7'h01, 32'h00000001});
    frame(8'h81, 32'h00000001, 40, -1, 1'b0, w);
    check("after_abort_wrcnt", 64'(wr_cnt), 64'(2));
    check("after_abort_ferr", 64'(err_cnt), 64'(1));

    // 48 SCLK cycles on a 40-bit write
    wr_q.push_back('{7'h03, 32'h12345678});
    frame(8'h83, 32'h12345678, 48, -1, 1'b1, w);
    check("long_wrcnt", 64'(wr_cnt), 64'(3));
    check("long_ferr", 64'(err_cnt), 64'(1));

    // Reset pulse at bit 15 loses the frame
    frame(8'h85, 32'hCAFEF00D, 40, 15, 1'b0, w);
    check("rstframe_wrcnt", 64'(wr_cnt), 64'(3));
    check("rstframe_ferr", 64'(err_cnt), 64'(1));
    check("rstframe_rdcnt", 64'(rd_cnt), 64'(1));

    // Max address write after the reset recovers
    wr_q.push_back('{7'h7F, 32'h0BADC0DE});
    frame(8'hFF, 32'h0BADC0DE, 40, -1, 1'b0, w);
    check("maxaddr_wrcnt", 64'(wr_cnt), 64'(4));

`ifdef SPI_SLAVE_IRQ_EN
    check("irq_set", 64'(bus.o_irq), 64'(1));
    clr_req++;
    repeat (3) @(negedge clk);
    check("irq_cleared", 64'(bus.o_irq), 64'(0));
    clr_on_wr = 1'b1;
    wr_q.push_back('{7'h10, 32'h55AA55AA});
    frame(8'h90, 32'h55AA55AA, 40, -1, 1'b0, w);
    clr_on_wr = 1'b0;
    check("irq_set_wins", 64'(bus.o_irq), 64'(1));
    check("irq_wrcnt", 64'(wr_cnt), 64'(5));
`else
    check("irq_tied_low", 64'(bus.o_irq), 64'(0));
    clr_req++;
    repeat (3) @(negedge clk);
    check("irq_tied_low_clr", 64'(bus.o_irq), 64'(0));
`endif

    check("wr_q_empty", 64'(wr_q.size()), 64'(0));
    check("rd_q_empty", 64'(rd_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI slave endpoint that terminates the far side of the bridge's SPI link and turns each SPI frame into a single-cycle register write or read on a parallel register port. It runs entirely in the FCLK_CLK0 domain. SCLK, MOSI and CS_N are oversampled through synchronizers, so it also serves as the loop-back responder when verifying the AXI-side SPI master. Frame: 8-bit header (bit 7 = write when 1 / read when 0, bits 6:0 = address) followed by DATA_W data bits, MSB first, SPI mode 0.

## Interface
- ADDR_W, 7: register address width; header bits ADDR_W-1:0 used, remaining header bits below bit 7 ignored (max 7).
- DATA_W, 32: data field width in bits.
- FCLK_CLK0  in  1  system clock, all logic rising-edge.
- RST_N  in  1  reset, asynchronous, active-low.
- i_sclk  in  1  SPI clock from master, asynchronous, idle low.
- i_cs_n  in  1  chip select, active-low, asynchronous.
- i_mosi  in  1  serial data from master.
- o_miso  out  1  serial data to master; 0 when not shifting read data.
- o_wr_en  out  1  one-cycle write strobe.
- o_wr_addr  out  ADDR_W  write address, valid with o_wr_en.
- o_wr_data  out  DATA_W  write data, valid with o_wr_en.
- o_rd_en  out  1  one-cycle read request.
- o_rd_addr  out  ADDR_W  read address, valid with o_rd_en.
- i_rd_data  in  DATA_W  read data, captured exactly one cycle after o_rd_en.
- o_busy  out  1  high while a frame is in progress.
- o_frame_err  out  1  one-cycle pulse on a short frame.
- o_irq  out  1  write-complete interrupt (see Configuration).
- i_irq_clr  in  1  clears o_irq.

## Operation
- Two-flop synchronizers on i_sclk, i_cs_n, i_mosi. Rise/fall detect is on the synchronized SCLK. MOSI is sampled on a detected rise, MISO updated on a detected fall.
- States: IDLE, HEADER, DATA, DRAIN.
- IDLE: o_busy=0. Synchronized CS_N falling → HEADER, bit counter=0, o_miso=0.
- HEADER: shifts 8 bits on SCLK rises. After the 8th bit → DATA.
  - Read header: pulse o_rd_en and o_rd_addr in the same cycle. Load i_rd_data into the TX shift register on the next cycle.
  - Write header: no read request is issued.
- DATA: shifts DATA_W bits.
  - Read: o_miso presents TX MSB from the first SCLK fall after the header, then one bit per fall.
  - Write: after the DATA_W-th rise, pulse o_wr_en with address and data for one cycle, then → DRAIN.
  - Read: after DATA_W rises → DRAIN.
- DRAIN: extra SCLK edges are ignored and o_miso=0. CS_N rise → IDLE.
- Synchronized CS_N rise in HEADER or DATA: abort, no o_wr_en, pulse o_frame_err for one cycle, → IDLE. An aborted read has already issued o_rd_en; this is allowed.
- CS_N rise and the final data rise detected in the same cycle: the frame counts as complete, o_wr_en fires, no o_frame_err.
- RST_N low mid-frame: all state cleared. The frame in flight is lost even after RST_N deasserts, until CS_N returns high and falls again.
- Reset values: o_miso=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_rd_en=0, o_rd_addr=0, o_busy=0, o_frame_err=0, o_irq=0. All shift registers and the counter are 0, state is IDLE.

## Timing
- SCLK frequency ≤ FCLK_CLK0/8. SCLK high and low phases each ≥ 4 FCLK cycles. CS_N falling to first SCLK rise ≥ 4 FCLK cycles.
- Input-to-detect latency: 3 FCLK cycles (2 sync + 1 edge register).
- o_wr_en asserts 3 cycles after the last data SCLK rise at the pin.
- o_rd_en asserts 3 cycles after the 8th SCLK rise at the pin. TX data is loaded 1 cycle later, before the 8th SCLK fall is detected.
- o_miso changes 3 cycles after an SCLK fall at the pin and is stable well before the next rise.
- o_busy rises 3 cycles after CS_N falls and falls 3 cycles after CS_N rises.

## Configuration
- SPI_SLAVE_IRQ_EN defined: o_irq is set on each o_wr_en cycle and held until i_irq_clr is high for one cycle. If set and clear occur in the same cycle, set wins.
- SPI_SLAVE_IRQ_EN undefined: o_irq is tied to 0, i_irq_clr is ignored, and no IRQ register is synthesized.

## Test plan
- Write frame header 0x85, data 0xDEADBEEF, SCLK = FCLK/8 → one o_wr_en with o_wr_addr=0x05, o_wr_data=0xDEADBEEF, no o_frame_err.
- Read frame header 0x02, i_rd_data=0xA5A5_0F0F one cycle after o_rd_en → o_rd_en once with o_rd_addr=0x02, and MISO bits sampled on SCLK rises = 0xA5A50F0F.
- CS_N released after 20 of 40 bits of write 0x81 → o_frame_err for one cycle, no o_wr_en. A following full write 0x81/0x00000001 succeeds.
- 48 SCLK cycles on write 0x83/0x12345678 → exactly one o_wr_en with data 0x12345678, and o_miso=0 during the extra 8 bits.
- RST_N pulsed low at bit 15 of a write frame → all outputs return to reset values immediately and no o_wr_en occurs for that frame.
- With SPI_SLAVE_IRQ_EN: write completes → o_irq=1; i_irq_clr pulse → o_irq=0; clear in the same cycle as o_wr_en → o_irq=1.
